// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with synchronous flush and an
// optional skid entry (SKID=1) so that in_ready comes straight from a register.
module pipe_stage_hs #(
  parameter int PAYLOAD_W = 114,
  parameter int SKID      = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic             in_xfer;
  logic             out_xfer;
  logic [1:0]       drop_amt;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign drop_cnt = drop_cnt_q;

  // drop_amt is entries held minus the one (if any) leaving this cycle.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_amt);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  generate
    if (SKID == 0) begin : g_single
      logic                 valid_q;
      logic                 valid_d;
      logic [PAYLOAD_W-1:0] data_q;
      logic [PAYLOAD_W-1:0] data_d;

      assign in_ready  = sys_rst & ~flush & (~valid_q | out_ready);
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign occupancy = {1'b0, valid_q};
      assign drop_amt  = {1'b0, valid_q & ~out_ready};

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_xfer) begin
          data_d  = in_data;
          valid_d = 1'b1;
        end else if (out_xfer) begin
          valid_d = 1'b0;
        end
        if (flush) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end else begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t               state_q;
      state_t               state_d;
      logic [PAYLOAD_W-1:0] main_q;
      logic [PAYLOAD_W-1:0] main_d;
      logic [PAYLOAD_W-1:0] skid_q;
      logic [PAYLOAD_W-1:0] skid_d;

      assign in_ready  = sys_rst & (state_q != TWO) & ~flush;
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
      // An out-transfer implies state_q is non-empty, so this cannot wrap.
      assign drop_amt  = state_q - {1'b0, out_xfer};

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_d  = in_data;
              state_d = ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              skid_d  = in_data;
              state_d = TWO;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench: u0 is single-entry, u1 has the skid entry, u2 is a skid
// stage with a 2-bit drop counter for saturation.
module tb_pipe_stage_hs;

  logic       clk;
  logic       rst_n;
  logic       rst1_n;

  logic       iv0, ir0, ov0, or0, fl0;
  logic [7:0] id0, od0;
  logic [1:0] occ0;
  logic [15:0] dc0;

  logic       iv1, ir1, ov1, or1, fl1;
  logic [7:0] id1, od1;
  logic [1:0] occ1;
  logic [15:0] dc1;

  logic       iv2, ir2, ov2, or2, fl2;
  logic [7:0] id2, od2;
  logic [1:0] occ2;
  logic [1:0] dc2;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_hs #(.PAYLOAD_W(8), .SKID(0), .CNT_W(16)) u0 (
    .sys_clk(clk), .sys_rst(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
    .occupancy(occ0), .drop_cnt(dc0));

  pipe_stage_hs #(.PAYLOAD_W(8), .SKID(1), .CNT_W(16)) u1 (
    .sys_clk(clk), .sys_rst(rst1_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
    .occupancy(occ1), .drop_cnt(dc1));

  pipe_stage_hs #(.PAYLOAD_W(8), .SKID(1), .CNT_W(2)) u2 (
    .sys_clk(clk), .sys_rst(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
    .occupancy(occ2), .drop_cnt(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iv1 = 1'b1;
    id1 = 8'hEE;
    step();
    n_vec++; if (ov0 !== 1'b0) begin $display("FAIL reset_ov0 got %0b want 0", ov0); n_err++; end
    n_vec++; if (occ1 !== 2'd0) begin $display("FAIL reset_occ1 got %0d want 0", occ1); n_err++; end
    n_vec++; if (dc1 !== 16'd0) begin $display("FAIL reset_dc1 got %0d want 0", dc1); n_err++; end
    n_vec++; if (od1 !== 8'h00) begin $display("FAIL reset_od1 got %h want 00", od1); n_err++; end
    n_vec++; if (ir1 !== 1'b0) begin $display("FAIL reset_ir1 got %0b want 0", ir1); n_err++; end
    iv1    = 1'b0;
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    step();
    $display("test_reset: reset state checked");
  endtask

  task automatic test_stream();
    iv0 = 1'b1; or0 = 1'b1;
    iv1 = 1'b1; or1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      id0 = 8'(i);
      id1 = 8'(i);
      #1;
      n_vec++; if (ir0 !== 1'b1) begin $display("FAIL stream_ir0[%0d] got %0b want 1", i, ir0); n_err++; end
      n_vec++; if (ir1 !== 1'b1) begin $display("FAIL stream_ir1[%0d] got %0b want 1", i, ir1); n_err++; end
      step();
      n_vec++; if (od0 !== 8'(i) || ov0 !== 1'b1 || occ0 !== 2'd1) begin
        $display("FAIL stream_u0[%0d] got data=%h v=%0b occ=%0d want data=%h v=1 occ=1", i, od0, ov0, occ0, 8'(i)); n_err++; end
      n_vec++; if (od1 !== 8'(i) || ov1 !== 1'b1 || occ1 !== 2'd1) begin
        $display("FAIL stream_u1[%0d] got data=%h v=%0b occ=%0d want data=%h v=1 occ=1", i, od1, ov1, occ1, 8'(i)); n_err++; end
      $display("test_stream: beat %0d u0=%h u1=%h", i, od0, od1);
    end
    iv0 = 1'b0;
    iv1 = 1'b0;
    step();
    n_vec++; if (ov0 !== 1'b0 || occ1 !== 2'd0) begin
      $display("FAIL stream_drain got ov0=%0b occ1=%0d want 0 0", ov0, occ1); n_err++; end
    or0 = 1'b0;
    or1 = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_out [3];
    exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h33;
    iv1 = 1'b1; or1 = 1'b0; id1 = 8'h11;
    step();
    id1 = 8'h22;
    #1;
    n_vec++; if (ir1 !== 1'b1) begin $display("FAIL bp_ir_one got %0b want 1", ir1); n_err++; end
    step();
    id1 = 8'h33;
    #1;
    n_vec++; if (occ1 !== 2'd2 || ir1 !== 1'b0) begin
      $display("FAIL bp_full got occ=%0d ir=%0b want occ=2 ir=0", occ1, ir1); n_err++; end
    step();
    n_vec++; if (occ1 !== 2'd2 || od1 !== 8'h11) begin
      $display("FAIL bp_hold got occ=%0d data=%h want occ=2 data=11", occ1, od1); n_err++; end
    or1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) iv1 = 1'b0;
      #1;
      n_vec++; if (ov1 !== 1'b1 || od1 !== exp_out[k]) begin
        $display("FAIL bp_out[%0d] got v=%0b data=%h want v=1 data=%h", k, ov1, od1, exp_out[k]); n_err++; end
      $display("test_back_pressure: drained %h", od1);
      step();
    end
    n_vec++; if (occ1 !== 2'd0 || ov1 !== 1'b0) begin
      $display("FAIL bp_empty got occ=%0d v=%0b want 0 0", occ1, ov1); n_err++; end
    or1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    iv1 = 1'b1; or1 = 1'b0; id1 = 8'h81;
    step();
    id1 = 8'h82;
    step();
    n_vec++; if (occ1 !== 2'd2) begin $display("FAIL rmid_fill got occ=%0d want 2", occ1); n_err++; end
    iv1 = 1'b0;
    #2 rst1_n = 1'b0;
    #1;
    n_vec++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || dc1 !== 16'd0 || od1 !== 8'h00 || ir1 !== 1'b0) begin
      $display("FAIL rmid_async got v=%0b occ=%0d dc=%0d data=%h ir=%0b want 0 0 0 00 0", ov1, occ1, dc1, od1, ir1); n_err++; end
    rst1_n = 1'b1;
    iv1 = 1'b1; id1 = 8'hA5;
    #1;
    n_vec++; if (ir1 !== 1'b1) begin $display("FAIL rmid_ir got %0b want 1", ir1); n_err++; end
    step();
    iv1 = 1'b0;
    n_vec++; if (ov1 !== 1'b1 || od1 !== 8'hA5 || occ1 !== 2'd1) begin
      $display("FAIL rmid_first got v=%0b data=%h occ=%0d want 1 a5 1", ov1, od1, occ1); n_err++; end
    $display("test_reset_mid: first after release %h", od1);
    or1 = 1'b1;
    step();
    or1 = 1'b0;
  endtask

  task automatic test_flush_drain();
    iv1 = 1'b1; or1 = 1'b0; id1 = 8'h44;
    step();
    id1 = 8'h55;
    step();
    id1 = 8'h77; fl1 = 1'b1; or1 = 1'b1;
    #1;
    n_vec++; if (ir1 !== 1'b0 || ov1 !== 1'b1 || od1 !== 8'h44) begin
      $display("FAIL fd_cycle got ir=%0b v=%0b data=%h want 0 1 44", ir1, ov1, od1); n_err++; end
    step();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    #1;
    n_vec++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || dc1 !== 16'd1 || ir1 !== 1'b1) begin
      $display("FAIL fd_after got v=%0b occ=%0d dc=%0d ir=%0b want 0 0 1 1", ov1, occ1, dc1, ir1); n_err++; end
    $display("test_flush_drain: drop_cnt=%0d", dc1);
    fl1 = 1'b1;
    step();
    fl1 = 1'b0;
    n_vec++; if (dc1 !== 16'd1) begin $display("FAIL fd_empty_flush got dc=%0d want 1", dc1); n_err++; end
  endtask

  task automatic test_flush_input();
    iv0 = 1'b1; id0 = 8'h66; fl0 = 1'b1; or0 = 1'b0;
    #1;
    n_vec++; if (ir0 !== 1'b0) begin $display("FAIL fi_ir got %0b want 0", ir0); n_err++; end
    step();
    fl0 = 1'b0; iv0 = 1'b0;
    n_vec++; if (ov0 !== 1'b0 || dc0 !== 16'd0) begin
      $display("FAIL fi_none got v=%0b dc=%0d want 0 0", ov0, dc0); n_err++; end
    iv0 = 1'b1; id0 = 8'h12;
    step();
    iv0 = 1'b0; fl0 = 1'b1;
    step();
    fl0 = 1'b0;
    n_vec++; if (ov0 !== 1'b0 || dc0 !== 16'd1) begin
      $display("FAIL fi_drop got v=%0b dc=%0d want 0 1", ov0, dc0); n_err++; end
    iv0 = 1'b1; id0 = 8'h34;
    step();
    iv0 = 1'b0; fl0 = 1'b1; or0 = 1'b1;
    #1;
    n_vec++; if (ov0 !== 1'b1 || od0 !== 8'h34) begin
      $display("FAIL fi_consume got v=%0b data=%h want 1 34", ov0, od0); n_err++; end
    step();
    fl0 = 1'b0; or0 = 1'b0;
    n_vec++; if (ov0 !== 1'b0 || dc0 !== 16'd1) begin
      $display("FAIL fi_drained got v=%0b dc=%0d want 0 1", ov0, dc0); n_err++; end
    $display("test_flush_input: drop_cnt=%0d", dc0);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_dc [3];
    exp_dc[0] = 2'd2; exp_dc[1] = 2'd3; exp_dc[2] = 2'd3;
    or2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv2 = 1'b1; id2 = 8'(8'h90 + k);
      step();
      id2 = 8'(8'hA0 + k);
      step();
      iv2 = 1'b0;
      n_vec++; if (occ2 !== 2'd2) begin $display("FAIL sat_fill[%0d] got occ=%0d want 2", k, occ2); n_err++; end
      fl2 = 1'b1;
      step();
      fl2 = 1'b0;
      n_vec++; if (dc2 !== exp_dc[k] || ov2 !== 1'b0) begin
        $display("FAIL sat_dc[%0d] got dc=%0d v=%0b want dc=%0d v=0", k, dc2, ov2, exp_dc[k]); n_err++; end
      $display("test_saturation: flush %0d drop_cnt=%0d", k, dc2);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b0; fl0 = 1'b0; id0 = '0;
    iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0; id1 = '0;
    iv2 = 1'b0; or2 = 1'b0; fl2 = 1'b0; id2 = '0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_reset_mid();
    test_flush_drain();
    test_flush_input();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
